// File: rtl/tinyrv1_mul_pkg.sv
// Shared encodings for the TinyRV1 iterative multiplier control and datapath.
// Latency: none (types and constants only).
// Backpressure: n/a.
package tinyrv1_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } mul_state_e;

   // A/B mux: take fresh operands or shift the held value
   localparam logic SEL_LOAD  = 1'b0;
   localparam logic SEL_SHIFT = 1'b1;

   // Result mux: zero the accumulator or add the current A
   localparam logic SEL_CLEAR = 1'b0;
   localparam logic SEL_ADD   = 1'b1;

endpackage

// File: rtl/iter_mul_counter.sv
// Iteration counter for the shift-add multiplier; flags the last step.
// Latency: terminal is a combinational decode of the registered count.
// Backpressure: none; counts only when the controller steps.
module iter_mul_counter #(
   parameter int NBITS = 32,
   parameter int CBITS = $clog2(NBITS)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   output logic terminal
);

   localparam logic [CBITS-1:0] LAST = CBITS'(NBITS - 1);

   logic [CBITS-1:0] cnt_q;
   logic [CBITS-1:0] cnt_d;

   // clear wins over inc so the last step can rewind to zero in the same edge
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CBITS'(1);
      end
   end

   // count register, cleared asynchronously
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign terminal = (cnt_q == LAST);

endmodule

// File: rtl/iter_mul_ctrl.sv
// Controller for the iterative shift-add multiplier: drives datapath selects/enables.
// Latency: accept to ostream_val is 2..NBITS+1 cycles, shortened when B runs out of ones.
// Backpressure: holds the product in DONE until ostream_rdy; no new operands until back in IDLE.
module iter_mul_ctrl
   import tinyrv1_mul_pkg::*;
#(
   parameter int NBITS = 32,
   parameter int CBITS = $clog2(NBITS)
) (
   input  logic clk,
   input  logic rst,
   input  logic istream_val,
   output logic istream_rdy,
   output logic ostream_val,
   input  logic ostream_rdy,
   input  logic b_lsb,
   input  logic b_zero,
   output logic a_mux_sel,
   output logic b_mux_sel,
   output logic res_mux_sel,
   output logic a_en,
   output logic b_en,
   output logic res_en
);

   mul_state_e state_q;
   mul_state_e state_d;
   logic       cnt_clr;
   logic       cnt_inc;
   logic       cnt_last;

   iter_mul_counter #(
      .NBITS (NBITS),
      .CBITS (CBITS)
   ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .clear    (cnt_clr),
      .inc      (cnt_inc),
      .terminal (cnt_last)
   );

   // state register; reset drops any in-flight product
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state and output decode; everything is forced low while reset is held
   always_comb begin
      state_d     = state_q;
      istream_rdy = 1'b0;
      ostream_val = 1'b0;
      a_mux_sel   = SEL_LOAD;
      b_mux_sel   = SEL_LOAD;
      res_mux_sel = SEL_CLEAR;
      a_en        = 1'b0;
      b_en        = 1'b0;
      res_en      = 1'b0;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;

      case (state_q)
         IDLE: begin
            istream_rdy = 1'b1;
            if (istream_val) begin
               a_en    = 1'b1;
               b_en    = 1'b1;
               res_en  = 1'b1;
               cnt_clr = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            // B exhausted: remaining steps would add nothing, finish early
            if (b_zero) begin
               state_d = DONE;
            end else begin
               a_mux_sel   = SEL_SHIFT;
               b_mux_sel   = SEL_SHIFT;
               res_mux_sel = SEL_ADD;
               a_en        = 1'b1;
               b_en        = 1'b1;
               res_en      = b_lsb;
               if (cnt_last) begin
                  cnt_clr = 1'b1;
                  state_d = DONE;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         DONE: begin
            ostream_val = 1'b1;
            if (ostream_rdy) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (!rst) begin
         istream_rdy = 1'b0;
         ostream_val = 1'b0;
         a_mux_sel   = 1'b0;
         b_mux_sel   = 1'b0;
         res_mux_sel = 1'b0;
         a_en        = 1'b0;
         b_en        = 1'b0;
         res_en      = 1'b0;
         cnt_clr     = 1'b0;
         cnt_inc     = 1'b0;
      end
   end

endmodule

// File: tb/tb_iter_mul_ctrl.sv
// Bench for iter_mul_ctrl with a behavioural shift-add datapath around it.
// Latency: checks accept-to-ostream_val cycle counts and products.
// Backpressure: exercises ostream_rdy stalls and idle gaps on istream.
module tb_iter_mul_ctrl;

   localparam int NBITS = 32;

   logic clk = 1'b0;
   logic rst;
   logic istream_val, istream_rdy, ostream_val, ostream_rdy;
   logic b_lsb, b_zero;
   logic a_mux_sel, b_mux_sel, res_mux_sel, a_en, b_en, res_en;

   logic [31:0] a_in, b_in, a_r, b_r, res_r;

   int total = 0;
   int bad = 0;
   int n_issued = 0;
   int n_out = 0;

   always #5 clk = ~clk;

   iter_mul_ctrl #(.NBITS(NBITS)) dut (
      .clk         (clk),
      .rst         (rst),
      .istream_val (istream_val),
      .istream_rdy (istream_rdy),
      .ostream_val (ostream_val),
      .ostream_rdy (ostream_rdy),
      .b_lsb       (b_lsb),
      .b_zero      (b_zero),
      .a_mux_sel   (a_mux_sel),
      .b_mux_sel   (b_mux_sel),
      .res_mux_sel (res_mux_sel),
      .a_en        (a_en),
      .b_en        (b_en),
      .res_en      (res_en)
   );

   // behavioural datapath steered by the controller
   always @(posedge clk) begin
      if (a_en)   a_r   <= a_mux_sel   ? (a_r << 1) : a_in;
      if (b_en)   b_r   <= b_mux_sel   ? (b_r >> 1) : b_in;
      if (res_en) res_r <= res_mux_sel ? (res_r + a_r) : 32'd0;
   end
   assign b_lsb  = b_r[0];
   assign b_zero = (b_r == 32'd0);

   // count product handshakes to catch lost or duplicated results
   always @(posedge clk) begin
      if (rst && ostream_val && ostream_rdy) n_out <= n_out + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] outs();
      return {istream_rdy, ostream_val, a_mux_sel, b_mux_sel, res_mux_sel, a_en, b_en, res_en};
   endfunction

   function automatic int lat_of(input logic [31:0] b);
      if (b == 32'd0) return 2;
      for (int i = 31; i >= 0; i--) begin
         if (b[i]) return (i + 3 > NBITS + 1) ? NBITS + 1 : i + 3;
      end
      return 2;
   endfunction

   // one full transaction: offer operands, time the product, stall, drain
   task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                          input logic [63:0] exp_pat, input bit chk_pat, input int hold,
                          input string tag);
      int          lat;
      int          guard;
      logic [63:0] pat;
      logic [31:0] exp_prod;
      exp_prod = a * b;
      @(negedge clk);
      guard = 0;
      while (!istream_rdy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!istream_rdy) begin
         check({tag, " rdy_timeout"}, 64'd0, 64'd1);
         return;
      end
      a_in = a;
      b_in = b;
      istream_val = 1'b1;
      lat = 0;
      pat = '0;
      do begin
         @(negedge clk);
         istream_val = 1'b0;
         lat++;
         if (!ostream_val) pat = {pat[62:0], res_en};
      end while (!ostream_val && lat < 100);
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " product"}, 64'(res_r), 64'(exp_prod));
      if (chk_pat) check({tag, " res_en_pattern"}, pat, exp_pat);
      for (int i = 0; i < hold; i++) begin
         check({tag, " stall_outs"}, 64'(outs()), 64'h40);
         @(negedge clk);
      end
      check({tag, " done_outs"}, 64'(outs()), 64'h40);
      check({tag, " held_product"}, 64'(res_r), 64'(exp_prod));
      ostream_rdy = 1'b1;
      n_issued++;
      @(negedge clk);
      ostream_rdy = 1'b0;
      check({tag, " back_to_idle"}, 64'({istream_rdy, ostream_val}), 64'b10);
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      logic [63:0] pat;
      int          hold;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{a: 32'd3,          b: 32'h8000_0000, lat: 33, pat: 64'h1,         hold: 0};
      vecs[1] = '{a: 32'h1234,       b: 32'd0,         lat: 2,  pat: 64'h0,         hold: 0};
      vecs[2] = '{a: 32'd9,          b: 32'd5,         lat: 5,  pat: 64'hA,         hold: 10};
      vecs[3] = '{a: 32'd7,          b: 32'd6,         lat: 5,  pat: 64'h6,         hold: 1};
      vecs[4] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF, lat: 33, pat: 64'hFFFF_FFFF, hold: 0};
      vecs[5] = '{a: 32'd0,          b: 32'd1,         lat: 3,  pat: 64'h2,         hold: 2};
      vecs[6] = '{a: 32'd101,        b: 32'h4000_0000, lat: 33, pat: 64'h2,         hold: 0};
      vecs[7] = '{a: 32'h0000_DEAD,  b: 32'h7FFF_FFFF, lat: 33, pat: 64'hFFFF_FFFE, hold: 3};

      // reset held with operands offered: everything must stay low
      rst = 1'b0;
      istream_val = 1'b1;
      ostream_rdy = 1'b0;
      a_in = 32'd11;
      b_in = 32'd13;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_outs", 64'(outs()), 64'h00);
      end
      rst = 1'b1;
      istream_val = 1'b0;
      @(negedge clk);
      check("idle_after_reset", 64'(outs()), 64'h80);
      @(negedge clk);
      check("idle_hold", 64'(outs()), 64'h80);
      istream_val = 1'b1;
      #1;
      check("idle_accept_decode", 64'(outs()), 64'h87);
      istream_val = 1'b0;

      // directed vector table
      for (int i = 0; i < 8; i++) begin
         run_txn(vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].pat, 1'b1, vecs[i].hold,
                 $sformatf("vec%0d", i));
      end

      // reset in the middle of CALC step 7
      @(negedge clk);
      a_in = 32'd5;
      b_in = 32'hFFFF_FFFF;
      istream_val = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         istream_val = 1'b0;
      end
      check("calc_step7_outs", 64'(outs()), 64'h3F);
      #2 rst = 1'b0;
      #1 check("midcalc_reset_outs", 64'(outs()), 64'h00);
      #1 rst = 1'b1;
      @(negedge clk);
      check("midcalc_reset_idle", 64'(outs()), 64'h80);
      run_txn(32'd7, 32'd6, 5, 64'h6, 1'b1, 0, "post_reset");

      // reset while the product is waiting in DONE
      @(negedge clk);
      a_in = 32'd4;
      b_in = 32'd0;
      istream_val = 1'b1;
      @(negedge clk);
      istream_val = 1'b0;
      @(negedge clk);
      check("done_before_reset", 64'(ostream_val), 64'd1);
      #2 rst = 1'b0;
      #1 check("done_reset_drop", 64'(outs()), 64'h00);
      #1 rst = 1'b1;
      @(negedge clk);
      check("done_reset_idle", 64'(outs()), 64'h80);

      // random operands with random idle gaps and consumer stalls
      for (int i = 0; i < 200; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 9) == 0) rb = 32'd0;
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_txn(ra, rb, lat_of(rb), 64'd0, 1'b0, $urandom_range(0, 4),
                 $sformatf("rnd%0d", i));
      end

      @(negedge clk);
      check("handshake_count", 64'(n_out), 64'(n_issued));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/iter_mul_ctrl.md
Name: iter_mul_ctrl

Overview:
- Control unit for the iterative shift-add multiplier used by the TinyRV1 `mul` path.
- Sequences a separate datapath made of resettable registers (A, B, result) and 2:1/3:1 muxes; this block issues mux selects and register enables.
- Owns the iteration counter and the latency-insensitive val/rdy handshakes on the operand stream (istream) and the product stream (ostream).

Parameters:
- NBITS, 32, operand/result width; sets iteration count. Legal values ≥ 2.
- CBITS, $clog2(NBITS), counter width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- istream_val  input  1  operands a, b valid on datapath inputs
- istream_rdy  output  1  controller can accept operands
- ostream_val  output  1  product in result register valid
- ostream_rdy  input  1  consumer accepts product
- b_lsb  input  1  bit 0 of B register (status from datapath)
- b_zero  input  1  B register == 0 (status from datapath)
- a_mux_sel  output  1  0 = load a from istream, 1 = A << 1
- b_mux_sel  output  1  0 = load b from istream, 1 = B >> 1
- res_mux_sel  output  1  0 = clear to 0, 1 = result + A
- a_en  output  1  A register enable
- b_en  output  1  B register enable
- res_en  output  1  result register enable

Behaviour:
- States (2-bit): IDLE=0, CALC=1, DONE=2. Encoding 3 is illegal; next state from 3 = IDLE.
- Reset (rst=0, async): state←IDLE, cnt←0.
  - While rst=0, all outputs = 0, including istream_rdy.
  - After release, outputs follow IDLE decode from the next evaluation.
- IDLE:
  - istream_rdy=1, ostream_val=0.
  - On istream_val=1: a_mux_sel=0, b_mux_sel=0, res_mux_sel=0, a_en=b_en=res_en=1, cnt←0, next=CALC.
  - Otherwise all enables 0; stay IDLE.
- CALC:
  - istream_rdy=0, ostream_val=0.
  - If b_zero=1: no enables; next=DONE (early termination, checked before stepping).
  - Else:
    - a_mux_sel=1, b_mux_sel=1, a_en=b_en=1.
    - res_mux_sel=1, res_en=b_lsb.
    - cnt←cnt+1.
    - If cnt==NBITS-1, next=DONE; cnt←0.
- DONE:
  - ostream_val=1; all enables 0; istream_rdy=0.
  - On ostream_rdy=1, next=IDLE. Otherwise hold; result must stay stable.
- Latency, from accept edge to first cycle with ostream_val=1:
  - Worst case: NBITS+1 cycles (NBITS CALC steps).
  - b=0: 2 cycles.
  - In general: 1 + (index of highest set bit of b) + 2, capped at NBITS+1.
- No overlap: istream_rdy is never 1 in DONE. Back-to-back transactions cost one IDLE cycle minimum.
- Counter wraps only via explicit clear. Counter is not incremented in IDLE or DONE. Counter never exceeds NBITS-1.
- Simultaneous istream_val and ostream_rdy in IDLE: ostream_rdy is ignored.
- Reset mid-CALC or mid-DONE: immediate return to IDLE.
  - The in-flight product is dropped; ostream_val falls asynchronously.
  - The datapath result register is not required to clear.
- All outputs are Moore or (state, status-input) combinational decode. No output depends on istream_val/ostream_rdy except enables and next state.

Decomposition:
- Shared package `tinyrv1_mul_pkg`: state encodings (IDLE/CALC/DONE), mux-select constants (SEL_LOAD=0, SEL_SHIFT=1, SEL_CLEAR=0, SEL_ADD=1).
- Sub-module `iter_mul_counter`:
  - CBITS-wide counter, async active-low reset.
  - Inputs: clear, inc.
  - Output: terminal (cnt==NBITS-1).
- State register and output decode live in iter_mul_ctrl.

Test Plan:
- Reset: rst=0 for 3 cycles with istream_val=1 → all outputs 0. After release → istream_rdy=1, state IDLE, no enables until istream_val.
- Full-length: a=3, b=0x80000000 (b_zero=0 until 32nd shift) → exactly 32 CALC cycles; ostream_val rises at cycle 33; res_en pulses only on the last step.
- Early exit: b=0 → CALC one cycle with no enables; ostream_val=1 at cycle 2. b=5 → ostream_val at cycle 5; res_en pattern 1,0,1.
- Back-pressure: product ready with ostream_rdy=0 for 10 cycles → ostream_val stays 1, all enables stay 0, istream_rdy=0. Raising ostream_rdy → IDLE next cycle, istream_rdy=1.
- Mid-operation reset: pulse rst=0 at CALC step 7 (between edges) → ostream_val/enables 0 immediately. Next transaction a=7, b=6 completes normally with cnt restarted at 0.
- Random stream: 200 random a/b pairs with random val/rdy stalls, run with the datapath model → every product equals a*b mod 2^32; no transaction lost or duplicated.
